// File: rtl/polyveck_power2round_seq.sv
`default_nettype none
// ============================================================================
//  Module   : polyveck_power2round_seq
//  Purpose  : Sequential Power2Round over a K-polynomial vector. It splits
//             each 32-bit signed coefficient a into a high part
//             t1 = (a + 2^(D-1) - 1) >>> D and a low part t0 = a - (t1 << D).
//             LANES coefficients are processed per clock, so a full vector
//             takes K*256/LANES cycles.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             start      - run request, accepted only while busy = 0
//             linear_t   - input vector, captured on the accepted start;
//                          coefficient i sits at bits [32i+31:32i]
//             busy       - high while a run is in progress
//             done       - one-cycle pulse when all results are written
//             linear_t1  - high parts, same packing as linear_t
//             linear_t0  - low parts, same packing as linear_t
//  Options  : POLYVECK_P2R_CADDQ_EN - when defined, a negative coefficient
//             first gets Q added, fused into the lane datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module polyveck_power2round_seq #(
    parameter int K     = 6,
    parameter int LANES = 8,
    parameter int D     = 13,
    parameter int Q     = 8380417
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [K*256*32-1:0]   linear_t,
    output logic                  busy,
    output logic                  done,
    output logic [K*256*32-1:0]   linear_t1,
    output logic [K*256*32-1:0]   linear_t0
);

    localparam int          c_ncoef = K * 256;
    localparam int          c_ngrp  = c_ncoef / LANES;
    localparam int          c_cw    = (c_ngrp > 1) ? $clog2(c_ngrp) : 1;
    localparam int          c_bits  = c_ncoef * 32;
    localparam int          c_iw    = $clog2(c_bits);
    localparam logic [31:0] c_round = 32'((1 << (D - 1)) - 1);
    localparam logic [31:0] c_q     = 32'(Q);
`ifdef POLYVECK_P2R_CADDQ_EN
    localparam logic        c_caddq_en = 1'b1;
`else
    localparam logic        c_caddq_en = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_cw-1:0]       r_cnt;
    logic [c_bits-1:0]     r_buf;

    // First coefficient index of the group currently being processed
    logic [31:0]           w_base;
    logic [c_iw-1:0]       w_idx [LANES];
    logic [31:0]           w_t1  [LANES];
    logic [31:0]           w_t0  [LANES];

    assign w_base = 32'(r_cnt) * 32'(LANES);

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [31:0] w_a;
            logic [31:0] w_ap;
            logic [31:0] w_sum;

            // Bit offset of this lane's coefficient (index * 32)
            assign w_idx[l] = c_iw'((w_base + 32'(l)) << 5);
            assign w_a      = r_buf[w_idx[l] +: 32];
            // Conditional add of Q folds a negative input into [0, Q-1]
            assign w_ap     = w_a + ((c_caddq_en && w_a[31]) ? c_q : 32'd0);
            assign w_sum    = w_ap + c_round;
            assign w_t1[l]  = 32'($signed(w_sum) >>> D);
            assign w_t0[l]  = w_ap - (w_t1[l] << D);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_buf     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            linear_t1 <= '0;
            linear_t0 <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_buf   <= linear_t;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        linear_t1[w_idx[l] +: 32] <= w_t1[l];
                        linear_t0[w_idx[l] +: 32] <= w_t0[l];
                    end
                    if (r_cnt == c_cw'(c_ngrp - 1)) begin
                        // Last group: results complete on this edge
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_polyveck_power2round_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_polyveck_power2round_seq
//  Purpose  : Self-checking bench for polyveck_power2round_seq. Instantiates
//             LANES=8, 6 and 1 builds and checks them against a floor-division
//             reference model of Power2Round.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_polyveck_power2round_seq;

    localparam int K  = 6;
    localparam int NC = K * 256;
    localparam int NB = NC * 32;
    localparam int QV = 8380417;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start_x = 1'b0;
    logic [NB-1:0] linear_t = '0;

    logic          busy8, done8, busy6, done6, busy1, done1;
    logic [NB-1:0] t1_8, t0_8, t1_6, t0_6, t1_1, t0_1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    polyveck_power2round_seq #(.K(K), .LANES(8), .D(13), .Q(QV)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .linear_t(linear_t),
        .busy(busy8), .done(done8), .linear_t1(t1_8), .linear_t0(t0_8));

    polyveck_power2round_seq #(.K(K), .LANES(6), .D(13), .Q(QV)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start_x), .linear_t(linear_t),
        .busy(busy6), .done(done6), .linear_t1(t1_6), .linear_t0(t0_6));

    polyveck_power2round_seq #(.K(K), .LANES(1), .D(13), .Q(QV)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_x), .linear_t(linear_t),
        .busy(busy1), .done(done1), .linear_t1(t1_1), .linear_t0(t0_1));

    // ---------------- reference model ----------------
    function automatic logic [31:0] caddq(input logic [31:0] a);
`ifdef POLYVECK_P2R_CADDQ_EN
        if (a[31]) return a + 32'(QV);
`endif
        return a;
    endfunction

    // t1 = floor((a' + 4095) / 8192), t0 = a' - 8192*t1
    task automatic ref_coef(input logic [31:0] a, output logic [31:0] t1, output logic [31:0] t0);
        longint ap, x, q;
        ap = longint'($signed(caddq(a)));
        x  = ap + 4095;
        if (x >= 0) q = x / 8192;
        else        q = -((-x + 8191) / 8192);
        t1 = q[31:0];
        t0 = 32'(ap - q * 8192);
    endtask

    task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic check_vec(input string name, input logic [NB-1:0] v,
                             input logic [NB-1:0] a1, input logic [NB-1:0] a0);
        logic [31:0] e1, e0;
        int bad;
        bad = -1;
        for (int i = 0; i < NC; i++) begin
            ref_coef(v[32*i +: 32], e1, e0);
            if (bad < 0 && (a1[32*i +: 32] !== e1 || a0[32*i +: 32] !== e0)) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            ref_coef(v[32*bad +: 32], e1, e0);
            $display("FAIL %s coef %0d: got t1=%0d t0=%0d, expected t1=%0d t0=%0d", name, bad,
                     $signed(a1[32*bad +: 32]), $signed(a0[32*bad +: 32]), $signed(e1), $signed(e0));
        end
    endtask

    task automatic check_inv(input string name, input logic [NB-1:0] v,
                             input logic [NB-1:0] a1, input logic [NB-1:0] a0);
        int bad;
        longint s;
        bad = -1;
        for (int i = 0; i < NC; i++) begin
            s = longint'($signed(a1[32*i +: 32])) * 8192 + longint'($signed(a0[32*i +: 32]));
            if (bad < 0 && s != longint'($signed(caddq(v[32*i +: 32])))) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s coef %0d: t1*8192+t0 differs from input %0d", name, bad,
                     $signed(v[32*bad +: 32]));
        end
    endtask

    task automatic rand_vec(output logic [NB-1:0] v);
        for (int i = 0; i < NC; i++) v[32*i +: 32] = 32'($urandom_range(0, QV - 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until done8 is seen
    task automatic wait_done8(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done8 && lat < 400);
        if (!done8) begin
            tests++;
            fails++;
            $display("FAIL done8_timeout: got no done, expected done within 400 cycles");
        end
    endtask

    task automatic run8(input logic [NB-1:0] v, output int lat);
        linear_t = v;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done8(lat);
    endtask

    // ---------------- boundary table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] t1;
        logic [31:0] t0;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [NB-1:0] va, vb, vt;
        int lat, lat6, lat1;

        tbl[0] = '{32'd0,       32'd0,    32'd0};
        tbl[1] = '{32'd4096,    32'd0,    32'd4096};
        tbl[2] = '{32'd4097,    32'd1,    -32'sd4095};
        tbl[3] = '{32'd8380416, 32'd1023, 32'd0};
        tbl[4] = '{32'd8191,    32'd1,    -32'sd1};
`ifdef POLYVECK_P2R_CADDQ_EN
        tbl[5] = '{-32'sd1,       32'd1023, 32'd0};
        tbl[6] = '{-32'sd8380417, 32'd0,    32'd0};
`else
        tbl[5] = '{-32'sd1,       32'd0,      -32'sd1};
        tbl[6] = '{-32'sd8380417, -32'sd1023, -32'sd1};
`endif

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_int("rst_busy", 32'(busy8), 0);
        check_int("rst_done", 32'(done8), 0);
        check_int("rst_t1_nonzero", 32'(t1_8 != '0), 0);
        check_int("rst_t0_nonzero", 32'(t0_8 != '0), 0);
        rst_n = 1'b1;
        step();

        // Boundary vector
        vt = '0;
        for (int i = 0; i < 7; i++) vt[32*i +: 32] = tbl[i].a;
        vt[32*(NC-1) +: 32] = 32'd8380416;
        run8(vt, lat);
        check_int("bnd_latency", 32'(lat), 192);
        for (int i = 0; i < 7; i++) begin
            check_int($sformatf("bnd_t1[%0d]", i), t1_8[32*i +: 32], tbl[i].t1);
            check_int($sformatf("bnd_t0[%0d]", i), t0_8[32*i +: 32], tbl[i].t0);
        end
        check_int("bnd_last_t1", t1_8[32*(NC-1) +: 32], 32'd1023);
        check_vec("bnd_model", vt, t1_8, t0_8);
        step();
        check_int("done_pulse_width", 32'(done8), 0);
        check_int("busy_after_done", 32'(busy8), 0);

        // Random in-range vector
        rand_vec(va);
        run8(va, lat);
        check_int("rand_latency", 32'(lat), 192);
        check_vec("rand_model", va, t1_8, t0_8);
        check_inv("rand_invariant", va, t1_8, t0_8);

        // start held high for the whole run, linear_t changed mid-run
        rand_vec(va);
        rand_vec(vb);
        linear_t = va;
        start = 1'b1;
        step();
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 20) linear_t = vb;
        end while (!done8 && lat < 400);
        start = 1'b0;
        check_int("held_latency", 32'(lat), 192);
        check_vec("held_result", va, t1_8, t0_8);
        repeat (3) step();
        check_int("held_single_run_busy", 32'(busy8), 0);

        // Back-to-back run with start in the done cycle
        rand_vec(va);
        rand_vec(vb);
        run8(va, lat);
        check_vec("b2b_first", va, t1_8, t0_8);
        linear_t = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        check_int("b2b_busy", 32'(busy8), 1);
        wait_done8(lat);
        check_int("b2b_latency", 32'(lat), 192);
        check_vec("b2b_second", vb, t1_8, t0_8);

        // Asynchronous reset mid-run
        rand_vec(va);
        linear_t = va;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        rst_n = 1'b0;
        #1;
        check_int("arst_busy", 32'(busy8), 0);
        check_int("arst_done", 32'(done8), 0);
        check_int("arst_t1_nonzero", 32'(t1_8 != '0), 0);
        check_int("arst_t0_nonzero", 32'(t0_8 != '0), 0);
        step();
        rst_n = 1'b1;
        step();
        rand_vec(vb);
        run8(vb, lat);
        check_int("arst_rerun_latency", 32'(lat), 192);
        check_vec("arst_rerun", vb, t1_8, t0_8);

        // LANES=6 and LANES=1 builds
        rand_vec(va);
        linear_t = va;
        start_x = 1'b1;
        step();
        start_x = 1'b0;
        lat6 = -1;
        lat1 = -1;
        for (int c = 1; c <= 2000; c++) begin
            step();
            if (done6 && lat6 < 0) begin
                lat6 = c;
                check_vec("l6_result", va, t1_6, t0_6);
            end
            if (done1 && lat1 < 0) begin
                lat1 = c;
                check_vec("l1_result", va, t1_1, t0_1);
            end
            if (lat6 >= 0 && lat1 >= 0) break;
        end
        check_int("l6_latency", 32'(lat6), 256);
        check_int("l1_latency", 32'(lat1), 1536);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
